addr_bus_arbiter: RTL and testbench

- Parametrised, clocked address-bus arbiter for the RAM address bus.
- Replaces a two-way PC/data select with a request/grant/ack handshake between one program-counter fetch channel and NUM_DATA data load/store channels.
- Latches the winner's address and write flag, holds them stable for a fixed access window, then acknowledges the owner.
- Sits between the PC, the memory controller's load/store ports, and the RAM.

---
 rtl/addr_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_addr_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_bus_arbiter.sv
// addr_bus_arbiter
//   Clocked arbiter for the RAM address bus. One program-counter fetch
//   channel (index NUM_DATA) and NUM_DATA data load/store channels
//   (indices 0..NUM_DATA-1) compete for the bus. The winner's address and
//   write flag are latched and held for ACCESS_CYCLES cycles. The owner is
//   then acknowledged with a one-cycle ack pulse. One IDLE turnaround
//   cycle always follows a transaction.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   pc_req       fetch request (channel NUM_DATA)
//   pc_address   fetch address, zero-extended onto the bus
//   data_req     per-channel data request, bit i = channel i
//   data_addr    flat address vector, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   data_we      per-channel write flag (1 = store)
//   address_bus  registered RAM address
//   mem_we       registered RAM write enable
//   grant        one-hot owner (bit NUM_DATA = PC), zero when idle
//   ack          one-hot completion pulse, subset of grant
//   bus_busy     high while a transaction owns the bus
module addr_bus_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int PC_WIDTH      = 8,
  parameter int NUM_DATA      = 2,
  parameter int ACCESS_CYCLES = 2,
  parameter int ARB_MODE      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pc_req,
  input  logic [PC_WIDTH-1:0]            pc_address,
  input  logic [NUM_DATA-1:0]            data_req,
  input  logic [NUM_DATA*ADDR_WIDTH-1:0] data_addr,
  input  logic [NUM_DATA-1:0]            data_we,
  output logic [ADDR_WIDTH-1:0]          address_bus,
  output logic                           mem_we,
  output logic [NUM_DATA:0]              grant,
  output logic [NUM_DATA:0]              ack,
  output logic                           bus_busy
);

  localparam int NCH   = NUM_DATA + 1;
  localparam int IDX_W = $clog2(NCH);
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    we_d;
  logic [NUM_DATA:0]       grant_d;

  logic [NUM_DATA:0]       req_all;
  int                      start_idx;
  int                      win_idx;
  logic                    win_found;
  logic [NUM_DATA:0]       win_oh;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    win_we;

  function automatic logic [ADDR_WIDTH-1:0] zext_pc(input logic [PC_WIDTH-1:0] pc);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    r[PC_WIDTH-1:0] = pc;
    return r;
  endfunction

  assign req_all = {pc_req, data_req};

  // Winner search. Fixed priority always starts at channel 0. Round-robin
  // starts one past the last owner and wraps, so the PC (highest index)
  // is followed by channel 0.
  always_comb begin
    start_idx = (ARB_MODE == 1) ? int'(rr_ptr_q) : 0;
    win_found = 1'b0;
    win_idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) begin
        if (!win_found && req_all[j] && (j == ((start_idx + i) % NCH))) begin
          win_found = 1'b1;
          win_idx   = j;
        end
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    win_addr = zext_pc(pc_address);
    win_we   = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      win_oh[j] = win_found && (j == win_idx);
    end
    for (int j = 0; j < NUM_DATA; j++) begin
      if (j == win_idx) begin
        win_addr = data_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        win_we   = data_we[j];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = address_bus;
    we_d     = mem_we;
    grant_d  = grant;
    unique case (state_q)
      IDLE: begin
        addr_d  = zext_pc(pc_address);
        we_d    = 1'b0;
        grant_d = '0;
        if (win_found) begin
          addr_d   = win_addr;
          we_d     = win_we;
          grant_d  = win_oh;
          cnt_d    = CNT_W'(ACCESS_CYCLES - 1);
          rr_ptr_d = IDX_W'((win_idx + 1) % NCH);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // Bus contents are frozen; requester inputs are not looked at.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          addr_d  = zext_pc(pc_address);
          we_d    = 1'b0;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulse comes from the last ACCESS cycle, so an aborted
  // (reset) transaction never acks.
  assign ack      = ((state_q == ACCESS) && (cnt_q == '0)) ? grant : '0;
  assign bus_busy = (state_q == ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      address_bus <= '0;
      mem_we      <= 1'b0;
      grant       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      address_bus <= addr_d;
      mem_we      <= we_d;
      grant       <= grant_d;
    end
  end

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed bench for addr_bus_arbiter: a fixed-priority instance (u0) and a
// round-robin instance (u1) share every input.
module tb_addr_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_req;
  logic [7:0]  pc_address;
  logic [1:0]  data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_we;

  logic [15:0] ab0, ab1;
  logic        we0, we1;
  logic [2:0]  g0, g1, a0, a1;
  logic        bb0, bb1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addr_bus_arbiter #(
    .ADDR_WIDTH(16), .PC_WIDTH(8), .NUM_DATA(2), .ACCESS_CYCLES(2), .ARB_MODE(0)
  ) u0 (
    .clk(clk), .reset(reset), .pc_req(pc_req), .pc_address(pc_address),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
    .address_bus(ab0), .mem_we(we0), .grant(g0), .ack(a0), .bus_busy(bb0)
  );

  addr_bus_arbiter #(
    .ADDR_WIDTH(16), .PC_WIDTH(8), .NUM_DATA(2), .ACCESS_CYCLES(2), .ARB_MODE(1)
  ) u1 (
    .clk(clk), .reset(reset), .pc_req(pc_req), .pc_address(pc_address),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
    .address_bus(ab1), .mem_we(we1), .grant(g1), .ack(a1), .bus_busy(bb1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int d, input logic [15:0] e_addr,
                     input logic e_we, input logic [2:0] e_gnt,
                     input logic [2:0] e_ack, input logic e_busy);
    logic [15:0] o_addr;
    logic        o_we;
    logic [2:0]  o_gnt;
    logic [2:0]  o_ack;
    logic        o_busy;
    if (d == 0) begin
      o_addr = ab0; o_we = we0; o_gnt = g0; o_ack = a0; o_busy = bb0;
    end else begin
      o_addr = ab1; o_we = we1; o_gnt = g1; o_ack = a1; o_busy = bb1;
    end
    checks++;
    assert (o_addr === e_addr) else begin
      errors++;
      $error("FAIL %s u%0d address_bus observed=%h expected=%h", tag, d, o_addr, e_addr);
    end
    checks++;
    assert (o_we === e_we) else begin
      errors++;
      $error("FAIL %s u%0d mem_we observed=%b expected=%b", tag, d, o_we, e_we);
    end
    checks++;
    assert (o_gnt === e_gnt) else begin
      errors++;
      $error("FAIL %s u%0d grant observed=%b expected=%b", tag, d, o_gnt, e_gnt);
    end
    checks++;
    assert (o_ack === e_ack) else begin
      errors++;
      $error("FAIL %s u%0d ack observed=%b expected=%b", tag, d, o_ack, e_ack);
    end
    checks++;
    assert (o_busy === e_busy) else begin
      errors++;
      $error("FAIL %s u%0d bus_busy observed=%b expected=%b", tag, d, o_busy, e_busy);
    end
  endtask

  initial begin
    reset      = 1'b1;
    pc_req     = 1'b0;
    pc_address = 8'hA5;
    data_req   = 2'b00;
    data_addr  = 32'h0;
    data_we    = 2'b00;

    // 1. reset, then idle with PC address on the bus
    tick();
    chk("rst1", 0, 16'h0000, 0, 3'b000, 3'b000, 0);
    chk("rst1", 1, 16'h0000, 0, 3'b000, 3'b000, 0);
    tick();
    chk("rst2", 0, 16'h0000, 0, 3'b000, 3'b000, 0);
    reset = 1'b0;
    tick();
    chk("idle_pc", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);
    chk("idle_pc", 1, 16'h00A5, 0, 3'b000, 3'b000, 0);

    // 2. single store on channel 1
    data_addr = {16'hBEEF, 16'h0000};
    data_we   = 2'b10;
    data_req  = 2'b10;
    tick();
    chk("st_c1", 0, 16'hBEEF, 1, 3'b010, 3'b000, 1);
    chk("st_c1", 1, 16'hBEEF, 1, 3'b010, 3'b000, 1);
    tick();
    chk("st_ack", 0, 16'hBEEF, 1, 3'b010, 3'b010, 1);
    data_req = 2'b00;
    tick();
    chk("st_idle", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);

    // 3. simultaneous requests, fixed priority: ch0, ch1, PC
    data_addr = {16'h2222, 16'h1111};
    data_we   = 2'b00;
    data_req  = 2'b11;
    pc_req    = 1'b1;
    tick();
    chk("fp_g0", 0, 16'h1111, 0, 3'b001, 3'b000, 1);
    chk("rr_after_c1", 1, 16'h00A5, 0, 3'b100, 3'b000, 1);
    tick();
    chk("fp_a0", 0, 16'h1111, 0, 3'b001, 3'b001, 1);
    data_req = 2'b10;
    tick();
    chk("fp_t0", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);
    tick();
    chk("fp_g1", 0, 16'h2222, 0, 3'b010, 3'b000, 1);
    tick();
    chk("fp_a1", 0, 16'h2222, 0, 3'b010, 3'b010, 1);
    data_req = 2'b00;
    tick();
    chk("fp_t1", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);
    tick();
    chk("fp_gpc", 0, 16'h00A5, 0, 3'b100, 3'b000, 1);
    tick();
    chk("fp_apc", 0, 16'h00A5, 0, 3'b100, 3'b100, 1);
    pc_req = 1'b0;
    tick();
    chk("fp_t2", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);
    chk("fp_t2", 1, 16'h00A5, 0, 3'b000, 3'b000, 0);

    // 4. all requesters held: round-robin rotates, fixed keeps ch0
    data_req = 2'b11;
    pc_req   = 1'b1;
    tick();
    chk("rr_g0", 1, 16'h1111, 0, 3'b001, 3'b000, 1);
    tick(); tick(); tick();
    chk("rr_g1", 1, 16'h2222, 0, 3'b010, 3'b000, 1);
    chk("fp_hold", 0, 16'h1111, 0, 3'b001, 3'b000, 1);
    tick(); tick(); tick();
    chk("rr_gpc", 1, 16'h00A5, 0, 3'b100, 3'b000, 1);
    tick(); tick(); tick();
    chk("rr_wrap", 1, 16'h1111, 0, 3'b001, 3'b000, 1);
    tick();
    chk("rr_wrap_ack", 1, 16'h1111, 0, 3'b001, 3'b001, 1);
    data_req = 2'b00;
    pc_req   = 1'b0;
    tick();
    chk("rr_idle", 1, 16'h00A5, 0, 3'b000, 3'b000, 0);
    chk("rr_idle", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);

    // 5. address change during ACCESS is ignored
    data_addr = {16'h2222, 16'h1234};
    data_req  = 2'b01;
    tick();
    chk("hold_g", 0, 16'h1234, 0, 3'b001, 3'b000, 1);
    data_addr = {16'h2222, 16'h5678};
    tick();
    chk("hold_a", 0, 16'h1234, 0, 3'b001, 3'b001, 1);
    chk("hold_a", 1, 16'h1234, 0, 3'b001, 3'b001, 1);
    data_req = 2'b00;
    tick();
    chk("hold_idle", 0, 16'h00A5, 0, 3'b000, 3'b000, 0);

    // 6. reset aborts a channel-1 store; no ack afterwards
    data_addr = {16'hBEEF, 16'h1234};
    data_we   = 2'b10;
    data_req  = 2'b10;
    tick();
    chk("ab_g", 1, 16'hBEEF, 1, 3'b010, 3'b000, 1);
    reset    = 1'b1;
    data_req = 2'b00;
    tick();
    chk("ab_rst", 0, 16'h0000, 0, 3'b000, 3'b000, 0);
    chk("ab_rst", 1, 16'h0000, 0, 3'b000, 3'b000, 0);
    reset    = 1'b0;
    data_we  = 2'b00;
    data_req = 2'b11;
    tick();
    chk("ab_post", 1, 16'h1234, 0, 3'b001, 3'b000, 1);
    chk("ab_post", 0, 16'h1234, 0, 3'b001, 3'b000, 1);
    tick();
    data_req = 2'b00;
    tick();

    // 7. pointer is cleared by reset: after a ch0 grant, ch0 still wins
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    data_req = 2'b11;
    tick();
    chk("rr_ptr_clr", 1, 16'h1234, 0, 3'b001, 3'b000, 1);
    tick();
    chk("rr_ptr_ack", 1, 16'h1234, 0, 3'b001, 3'b001, 1);
    data_req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
